// File: rtl/inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetcher
// Brief    : Single-outstanding instruction fetch FSM with static next-PC
//            prediction, feeding a circular instruction queue to the issuer.
//            Define BRANCH_PREDICT_EN to predict backward B-type branches taken.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetcher #(
    parameter int          QUEUE_SIZE_LOG = 2,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        is_any_full,
    output logic        ready_to_issuer,
    output logic [31:0] pc_to_issuer,
    output logic [31:0] next_pc_to_issuer,
    output logic [31:0] inst_to_issuer,
    output logic        valid_to_mem_ctrl,
    output logic [31:0] addr_to_mem_ctrl,
    input  logic        ready_from_mem_ctrl,
    input  logic [31:0] inst_from_mem_ctrl,
    input  logic        reset_from_rob_bus,
    input  logic [31:0] pc_from_rob_bus
);

    localparam int                        C_DEPTH     = 1 << QUEUE_SIZE_LOG;
    localparam int                        C_CNT_W     = QUEUE_SIZE_LOG + 1;
    localparam logic [C_CNT_W-1:0]        C_DEPTH_CNT = C_CNT_W'(C_DEPTH);
    localparam logic [C_CNT_W-1:0]        C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [QUEUE_SIZE_LOG-1:0] C_PTR_ONE   = QUEUE_SIZE_LOG'(1);
    localparam logic [6:0]                C_OP_JAL    = 7'b1101111;
`ifdef BRANCH_PREDICT_EN
    localparam logic [6:0]                C_OP_BRANCH = 7'b1100011;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [31:0]               r_fetch_pc;
    logic [31:0]               w_fetch_pc_nxt;
    logic                      w_valid_nxt;
    logic [31:0]               w_addr_nxt;
    logic                      w_enq;
    logic                      w_push;
    logic                      w_pop;
    logic [31:0]               w_pred_pc;
    logic [31:0]               w_imm_j;
    logic [QUEUE_SIZE_LOG-1:0] r_head;
    logic [QUEUE_SIZE_LOG-1:0] r_tail;
    logic [C_CNT_W-1:0]        r_count;

    logic [31:0] r_q_pc   [C_DEPTH];
    logic [31:0] r_q_npc  [C_DEPTH];
    logic [31:0] r_q_inst [C_DEPTH];

    assign ready_to_issuer   = rdy && (r_count != '0) && !reset_from_rob_bus;
    assign pc_to_issuer      = r_q_pc[r_head];
    assign next_pc_to_issuer = r_q_npc[r_head];
    assign inst_to_issuer    = r_q_inst[r_head];

    assign w_push = rdy && w_enq;
    assign w_pop  = ready_to_issuer && !is_any_full;

    assign w_imm_j = {{12{inst_from_mem_ctrl[31]}}, inst_from_mem_ctrl[19:12],
                      inst_from_mem_ctrl[20], inst_from_mem_ctrl[30:21], 1'b0};
`ifdef BRANCH_PREDICT_EN
    logic [31:0] w_imm_b;
    assign w_imm_b = {{20{inst_from_mem_ctrl[31]}}, inst_from_mem_ctrl[7],
                      inst_from_mem_ctrl[30:25], inst_from_mem_ctrl[11:8], 1'b0};
`endif

    // Static prediction; JALR targets need register values, so fall through.
    always_comb begin
        w_pred_pc = r_fetch_pc + 32'd4;
        if (inst_from_mem_ctrl[6:0] == C_OP_JAL) begin
            w_pred_pc = r_fetch_pc + w_imm_j;
        end
`ifdef BRANCH_PREDICT_EN
        else if (inst_from_mem_ctrl[6:0] == C_OP_BRANCH && inst_from_mem_ctrl[31]) begin
            w_pred_pc = r_fetch_pc + w_imm_b;
        end
`endif
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_valid_nxt    = valid_to_mem_ctrl;
        w_addr_nxt     = addr_to_mem_ctrl;
        w_enq          = 1'b0;
        if (reset_from_rob_bus) begin
            w_fetch_pc_nxt = pc_from_rob_bus;
            w_valid_nxt    = 1'b0;
            // A request still in flight must have its response swallowed later.
            if (r_state != S_IDLE && !ready_from_mem_ctrl) begin
                w_state_nxt = S_DISCARD;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < C_DEPTH_CNT) begin
                        w_valid_nxt = 1'b1;
                        w_addr_nxt  = r_fetch_pc;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ready_from_mem_ctrl) begin
                        w_enq          = 1'b1;
                        w_fetch_pc_nxt = w_pred_pc;
                        w_valid_nxt    = 1'b0;
                        w_state_nxt    = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (ready_from_mem_ctrl) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_fetch_pc        <= RESET_PC;
            valid_to_mem_ctrl <= 1'b0;
            addr_to_mem_ctrl  <= 32'h0;
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
        end else if (rdy) begin
            r_state           <= w_state_nxt;
            r_fetch_pc        <= w_fetch_pc_nxt;
            valid_to_mem_ctrl <= w_valid_nxt;
            addr_to_mem_ctrl  <= w_addr_nxt;
            if (reset_from_rob_bus) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + C_PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + C_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + C_CNT_ONE;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - C_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]   <= r_fetch_pc;
            r_q_npc[r_tail]  <= w_pred_pc;
            r_q_inst[r_tail] <= inst_from_mem_ctrl;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// Testbench for inst_fetcher: scoreboards the issuer stream and the fetch-address stream.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        is_any_full = 1'b0;
    logic        ready_to_issuer;
    logic [31:0] pc_to_issuer;
    logic [31:0] next_pc_to_issuer;
    logic [31:0] inst_to_issuer;
    logic        valid_to_mem_ctrl;
    logic [31:0] addr_to_mem_ctrl;
    logic        ready_from_mem_ctrl = 1'b0;
    logic [31:0] inst_from_mem_ctrl = 32'h0;
    logic        reset_from_rob_bus = 1'b0;
    logic [31:0] pc_from_rob_bus = 32'h0;

    always #5 clk = ~clk;

    inst_fetcher dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .is_any_full         (is_any_full),
        .ready_to_issuer     (ready_to_issuer),
        .pc_to_issuer        (pc_to_issuer),
        .next_pc_to_issuer   (next_pc_to_issuer),
        .inst_to_issuer      (inst_to_issuer),
        .valid_to_mem_ctrl   (valid_to_mem_ctrl),
        .addr_to_mem_ctrl    (addr_to_mem_ctrl),
        .ready_from_mem_ctrl (ready_from_mem_ctrl),
        .inst_from_mem_ctrl  (inst_from_mem_ctrl),
        .reset_from_rob_bus  (reset_from_rob_bus),
        .pc_from_rob_bus     (pc_from_rob_bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } ent_t;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef BRANCH_PREDICT_EN
    localparam logic [31:0] BR_TGT = 32'h18;
`else
    localparam logic [31:0] BR_TGT = 32'h24;
`endif

    ent_t        exp_q[$];
    logic [31:0] exp_req[$];
    logic [31:0] mem [logic [31:0]];
    int          n_chk = 0;
    int          n_fail = 0;
    int          budget = 0;
    int          resp_cnt = 0;
    logic        busy = 1'b0;
    logic [31:0] req_addr = 32'h0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : NOP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    task automatic push_ent(input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] inst);
        ent_t e;
        e.pc = pc; e.npc = npc; e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory model: accepts one request, answers only while responses remain in budget.
    always @(negedge clk) begin
        if (rst) begin
            busy                = 1'b0;
            resp_cnt            = 0;
            ready_from_mem_ctrl = 1'b0;
        end else begin
            ready_from_mem_ctrl = 1'b0;
            if (rdy) begin
                if (busy && resp_cnt < budget) begin
                    ready_from_mem_ctrl = 1'b1;
                    inst_from_mem_ctrl  = mem_rd(req_addr);
                    busy                = 1'b0;
                    resp_cnt++;
                end else if (!busy && valid_to_mem_ctrl) begin
                    busy     = 1'b1;
                    req_addr = addr_to_mem_ctrl;
                    if (exp_req.size() == 0) fail_evt("req_unexpected", addr_to_mem_ctrl);
                    else chk("req_addr", addr_to_mem_ctrl, exp_req.pop_front());
                end
            end
        end
    end

    // Issuer-side monitor: an entry is consumed at the next edge when this holds.
    always @(negedge clk) begin : mon
        ent_t e;
        if (!rst && ready_to_issuer && !is_any_full) begin
            if (exp_q.size() == 0) begin
                fail_evt("deq_unexpected", pc_to_issuer);
            end else begin
                e = exp_q.pop_front();
                chk("deq_pc", pc_to_issuer, e.pc);
                chk("deq_next_pc", next_pc_to_issuer, e.npc);
                chk("deq_inst", inst_to_issuer, e.inst);
            end
        end
    end

    task automatic wait_idle(input string name, input int max_cycles);
        int i = 0;
        while ((exp_q.size() != 0 || exp_req.size() != 0) && i < max_cycles) begin
            step();
            i++;
        end
        n_chk++;
        if (exp_q.size() != 0 || exp_req.size() != 0) begin
            n_fail++;
            $display("FAIL %s: timeout with %0d entries and %0d requests outstanding",
                     name, exp_q.size(), exp_req.size());
            exp_q.delete();
            exp_req.delete();
        end
        repeat (4) step();
    endtask

    task automatic do_reset(input logic [31:0] start_pc, input bit redirect);
        rst                = 1'b1;
        rdy                = 1'b1;
        is_any_full        = 1'b0;
        reset_from_rob_bus = 1'b0;
        step();
        chk("rst_valid", 32'(valid_to_mem_ctrl), 32'h0);
        chk("rst_addr", addr_to_mem_ctrl, 32'h0);
        chk("rst_ready", 32'(ready_to_issuer), 32'h0);
        step();
        rst = 1'b0;
        if (redirect) begin
            reset_from_rob_bus = 1'b1;
            pc_from_rob_bus    = start_pc;
            step();
            reset_from_rob_bus = 1'b0;
            chk("redirect_no_req", 32'(valid_to_mem_ctrl), 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem[32'h00]  = 32'h00100093;
        mem[32'h04]  = 32'h00200113;
        mem[32'h08]  = 32'h00300193;
        mem[32'h0C]  = 32'h000080E7;
        mem[32'h10]  = 32'hFFDFF06F;
        mem[32'h18]  = 32'h00000463;
        mem[32'h20]  = 32'hFE000CE3;
        mem[32'h100] = 32'h010000EF;

        // Straight-line addi stream from reset.
        exp_req = {32'h0, 32'h4, 32'h8, 32'hC};
        push_ent(32'h0, 32'h4, 32'h00100093);
        push_ent(32'h4, 32'h8, 32'h00200113);
        push_ent(32'h8, 32'hC, 32'h00300193);
        do_reset(32'h0, 1'b0);
        budget = 3;
        step();
        chk("first_req_valid", 32'(valid_to_mem_ctrl), 32'h1);
        chk("first_req_addr", addr_to_mem_ctrl, 32'h0);
        wait_idle("seq", 60);
        chk("held_req_addr", addr_to_mem_ctrl, 32'hC);

        // JAL +16 redirects the fetch stream.
        exp_req = {32'h100, 32'h110, 32'h114};
        push_ent(32'h100, 32'h110, 32'h010000EF);
        push_ent(32'h110, 32'h114, NOP);
        do_reset(32'h100, 1'b1);
        budget = 2;
        wait_idle("jal", 60);

        // Backward BEQ: taken only when branch prediction is built in.
        exp_req = {32'h20, BR_TGT, BR_TGT + 32'd4};
        push_ent(32'h20, BR_TGT, 32'hFE000CE3);
        push_ent(BR_TGT, BR_TGT + 32'd4, mem_rd(BR_TGT));
        do_reset(32'h20, 1'b1);
        budget = 2;
        wait_idle("beq", 60);

        // Queue fills under stall, freezes with rdy low, then drains.
        exp_req = {32'h0, 32'h4, 32'h8, 32'hC};
        do_reset(32'h0, 1'b0);
        is_any_full = 1'b1;
        budget = 4;
        repeat (20) step();
        chk("full_req_count", 32'(exp_req.size()), 32'h0);
        chk("full_no_fifth_req", 32'(valid_to_mem_ctrl), 32'h0);
        chk("full_head_ready", 32'(ready_to_issuer), 32'h1);
        rdy = 1'b0;
        is_any_full = 1'b0;
        repeat (3) step();
        chk("frozen_ready", 32'(ready_to_issuer), 32'h0);
        push_ent(32'h0, 32'h4, 32'h00100093);
        push_ent(32'h4, 32'h8, 32'h00200113);
        push_ent(32'h8, 32'hC, 32'h00300193);
        push_ent(32'hC, 32'h10, 32'h000080E7);
        push_ent(32'h10, 32'hC, 32'hFFDFF06F);
        exp_req = {32'h10, 32'hC};
        budget = 5;
        rdy = 1'b1;
        wait_idle("drain", 80);

        // Flush one cycle before the outstanding response arrives.
        exp_req = {32'h0};
        do_reset(32'h0, 1'b0);
        budget = 0;
        wait_idle("flush_setup", 20);
        reset_from_rob_bus = 1'b1;
        pc_from_rob_bus    = 32'h200;
        step();
        reset_from_rob_bus = 1'b0;
        chk("flush_ready", 32'(ready_to_issuer), 32'h0);
        chk("flush_valid", 32'(valid_to_mem_ctrl), 32'h0);
        exp_req = {32'h200, 32'h204, 32'h208};
        push_ent(32'h200, 32'h204, NOP);
        push_ent(32'h204, 32'h208, NOP);
        budget = 3;
        wait_idle("flush_late", 60);

        // Flush coinciding with a would-be dequeue and a response.
        exp_req = {32'h0, 32'h4};
        do_reset(32'h0, 1'b0);
        is_any_full = 1'b1;
        budget = 1;
        wait_idle("coinc_setup", 30);
        chk("coinc_pre_ready", 32'(ready_to_issuer), 32'h1);
        reset_from_rob_bus = 1'b1;
        pc_from_rob_bus    = 32'h300;
        is_any_full        = 1'b0;
        budget             = 2;
        step();
        reset_from_rob_bus = 1'b0;
        chk("coinc_ready", 32'(ready_to_issuer), 32'h0);
        chk("coinc_valid", 32'(valid_to_mem_ctrl), 32'h0);
        exp_req = {32'h300, 32'h304};
        push_ent(32'h300, 32'h304, NOP);
        budget = 3;
        wait_idle("coinc", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have parameter QUEUE_SIZE_LOG, default 2, meaning log2 of instruction-queue depth.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning the fetch PC after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-006 SHALL have port is_any_full  input  1  downstream stall; high blocks a dequeue.
REQ-007 SHALL have port ready_to_issuer  output  1  queue head valid.
REQ-008 SHALL have port pc_to_issuer  output  32  head instruction PC.
REQ-009 SHALL have port next_pc_to_issuer  output  32  head predicted next PC.
REQ-010 SHALL have port inst_to_issuer  output  32  head instruction word.
REQ-011 SHALL have port valid_to_mem_ctrl  output  1  fetch request pending (registered).
REQ-012 SHALL have port addr_to_mem_ctrl  output  32  fetch address (registered).
REQ-013 SHALL have port ready_from_mem_ctrl  input  1  one-cycle pulse, response valid.
REQ-014 SHALL have port inst_from_mem_ctrl  input  32  fetched word, valid with ready pulse.
REQ-015 SHALL have port reset_from_rob_bus  input  1  mispredict flush.
REQ-016 SHALL have port pc_from_rob_bus  input  32  redirect target, valid with flush.

Function
REQ-017 SHALL hold a circular FIFO of 2^QUEUE_SIZE_LOG entries {pc, next_pc, inst} with head, tail and count registers; pointers wrap modulo depth.
REQ-018 SHALL drive ready_to_issuer = rdy && count!=0 && !reset_from_rob_bus; head fields are combinational from the queue head.
REQ-019 SHALL dequeue on a rising edge when ready_to_issuer && !is_any_full (issuer consumes in that same cycle).
REQ-020 SHALL run fetch FSM IDLE/WAIT/DISCARD with at most one outstanding memory request.
REQ-021 IDLE: if count < depth, SHALL set valid_to_mem_ctrl<=1 and addr_to_mem_ctrl<=fetch_pc, then go to WAIT; otherwise SHALL stay in IDLE.
REQ-022 WAIT: on ready_from_mem_ctrl, SHALL enqueue {fetch_pc, predicted, inst_from_mem_ctrl}, set fetch_pc<=predicted, clear valid_to_mem_ctrl and go to IDLE.
REQ-023 Prediction: JAL (opcode 1101111) SHALL predict pc+J-imm; B-type (1100011) SHALL follow REQ-033/034; all other opcodes, JALR included, SHALL predict pc+4; arithmetic is 32-bit wrap-around.
REQ-024 Simultaneous enqueue and dequeue SHALL leave count unchanged; overflow is impossible by REQ-021.
REQ-025 Flush (reset_from_rob_bus high) SHALL have priority over every other event: count/head/tail<=0, fetch_pc<=pc_from_rob_bus, valid_to_mem_ctrl<=0, and no enqueue or dequeue in that cycle.
REQ-026 Flush while in WAIT without ready_from_mem_ctrl SHALL go to DISCARD; flush coincident with ready_from_mem_ctrl SHALL drop the word and go to IDLE.
REQ-027 DISCARD SHALL drop the next ready_from_mem_ctrl response and go to IDLE; a further flush in DISCARD SHALL update fetch_pc and stay in DISCARD.
REQ-028 rdy low SHALL hold every register; a ready_from_mem_ctrl pulse is never asserted while rdy is low.

Reset
REQ-029 rst SHALL asynchronously set fetch_pc=RESET_PC, head=tail=count=0, state=IDLE.
REQ-030 During rst, outputs SHALL be valid_to_mem_ctrl=0, addr_to_mem_ctrl=0 and ready_to_issuer=0; head fields are don't-care.
REQ-031 rst asserted mid-request SHALL abandon the request; the memory controller is reset by the same rst.
REQ-032 The first request SHALL issue on the first rdy clock edge after rst deasserts.

Configuration
REQ-033 With BRANCH_PREDICT_EN defined, a B-type branch with a negative immediate SHALL predict pc+B-imm and one with a non-negative immediate SHALL predict pc+4.
REQ-034 Without BRANCH_PREDICT_EN, every B-type branch SHALL predict pc+4; JAL prediction SHALL be unchanged in both builds.

Verification
REQ-035 Stimulus: rst, then memory returns addi words at 0,4,8 with 1-cycle latency and is_any_full=0 -> the issuer sees pc 0,4,8 with next_pc 4,8,12 in order.
REQ-036 Stimulus: JAL +16 at pc 0x100 -> the entry has next_pc=0x110 and the next request address is 0x110.
REQ-037 Stimulus: BEQ imm=-8 at pc 0x20 -> next_pc=0x18 with BRANCH_PREDICT_EN and 0x24 without it.
REQ-038 Stimulus: is_any_full=1 held while memory answers every request -> exactly 4 entries queued, no fifth request, then draining resumes fetch.
REQ-039 Stimulus: flush to 0x200 one cycle before an outstanding response -> the late word is dropped, ready_to_issuer=0 until the word from 0x200 arrives, and the next request is to 0x200.
REQ-040 Stimulus: flush coincident with a dequeue and a response -> count=0, neither word delivered, and the next request is to pc_from_rob_bus.
